// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light front end.
package tlc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } req_state_t;

   localparam int DEBOUNCE_DEFAULT = 4;
   localparam int SYNC_STAGES      = 2;

endpackage

// File: rtl/sensor_debounce.sv
// One loop-sensor channel: 2-flop synchronizer, level debouncer and
// accept pulse marking each debounced 0->1 transition.
module sensor_debounce
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic sens,
   output logic stable,
   output logic arr
);

   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             dcnt;
   logic                   s;
   logic                   accept;

   assign s      = sync_q[SYNC_STAGES-1];
   assign accept = (s != stable) && (dcnt == LAST);
   // arr fires on the edge that accepts a rising level, so the request
   // FSM can see it while stable is still 0
   assign arr    = accept & s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         stable <= 1'b0;
         dcnt   <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sens};
         if (s == stable) begin
            dcnt <= '0;
         end else if (accept) begin
            stable <= s;
            dcnt   <= '0;
         end else begin
            dcnt <= dcnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/vehicle_detect.sv
// Sticky vehicle requests Xh/Xc from bouncy loop sensors, cleared by green.
// Optional saturating arrival counters under VD_COUNT_EN.
module vehicle_detect
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef VD_COUNT_EN
 , parameter int CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic sens_h,
   input  logic sens_c,
   input  logic Gh,
   input  logic Gc,
   output logic Xh,
   output logic Xc
`ifdef VD_COUNT_EN
 , output logic [CNT_W-1:0] cnt_h
 , output logic [CNT_W-1:0] cnt_c
`endif
);

   logic       stable_h, stable_c;
   logic       arr_h, arr_c;
   req_state_t state_h, state_c;
   req_state_t next_h, next_c;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_h (
      .clk    (clk),
      .reset  (reset),
      .sens   (sens_h),
      .stable (stable_h),
      .arr    (arr_h)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
      .clk    (clk),
      .reset  (reset),
      .sens   (sens_c),
      .stable (stable_c),
      .arr    (arr_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_h <= IDLE;
         state_c <= IDLE;
      end else begin
         state_h <= next_h;
         state_c <= next_c;
      end
   end

   // a fresh arrival outranks a simultaneous service clear
   always_comb begin
      next_h = state_h;
      next_c = state_c;
      unique case (state_h)
         IDLE: if (stable_h) next_h = WAIT;
         WAIT: if (Gh && !stable_h && !arr_h) next_h = IDLE;
         default: next_h = IDLE;
      endcase
      unique case (state_c)
         IDLE: if (stable_c) next_c = WAIT;
         WAIT: if (Gc && !stable_c && !arr_c) next_c = IDLE;
         default: next_c = IDLE;
      endcase
   end

   assign Xh = (state_h == WAIT);
   assign Xc = (state_c == WAIT);

`ifdef VD_COUNT_EN
   logic [CNT_W-1:0] count_h, count_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_h <= '0;
         count_c <= '0;
      end else begin
         if (arr_h && (count_h != '1)) count_h <= count_h + 1'b1;
         if (arr_c && (count_c != '1)) count_c <= count_c + 1'b1;
      end
   end

   assign cnt_h = count_h;
   assign cnt_c = count_c;
`endif

endmodule

// File: tb/tb_vehicle_detect.sv
// Self-checking bench for vehicle_detect with DEBOUNCE_CYCLES=4.
module tb_vehicle_detect;

   typedef struct {
      string name;
      logic  rst;
      logic  sh;
      logic  sc;
      logic  gh;
      logic  gc;
      int    n;
      logic  xh;
      logic  xc;
   } vec_t;

   typedef struct {
      string name;
      logic  xh;
      logic  xc;
   } exp_t;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic sens_h = 1'b0;
   logic sens_c = 1'b0;
   logic Gh     = 1'b0;
   logic Gc     = 1'b0;
   logic Xh, Xc;
`ifdef VD_COUNT_EN
   logic [1:0] cnt_h, cnt_c;
`endif

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   vehicle_detect #(
      .DEBOUNCE_CYCLES(4)
`ifdef VD_COUNT_EN
    , .CNT_W(2)
`endif
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sens_h (sens_h),
      .sens_c (sens_c),
      .Gh     (Gh),
      .Gc     (Gc),
      .Xh     (Xh),
      .Xc     (Xc)
`ifdef VD_COUNT_EN
    , .cnt_h  (cnt_h)
    , .cnt_c  (cnt_c)
`endif
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic add(input string name, input logic rst, input logic sh,
                      input logic sc, input logic gh, input logic gc,
                      input int n, input logic xh, input logic xc);
      vec_t v;
      v.name = name; v.rst = rst; v.sh = sh; v.sc = sc;
      v.gh = gh; v.gc = gc; v.n = n; v.xh = xh; v.xc = xc;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      reset  = v.rst;
      sens_h = v.sh;
      sens_c = v.sc;
      Gh     = v.gh;
      Gc     = v.gc;
      exp_q.push_back('{name: v.name, xh: v.xh, xc: v.xc});
      if (v.n > 0) begin
         repeat (v.n) @(posedge clk);
         @(negedge clk);
      end else begin
         #1;
      end
      e = exp_q.pop_front();
      check({e.name, ".Xh"}, int'(Xh), int'(e.xh));
      check({e.name, ".Xc"}, int'(Xc), int'(e.xc));
   endtask

   initial begin
      //   name          rst sh sc gh gc  n  xh xc
      add("rst0",        0,  0, 0, 0, 0,  0, 0, 0);
      add("rst_hold",    0,  1, 1, 0, 0,  3, 0, 0);
      add("rise_6",      1,  1, 1, 0, 0,  6, 0, 0);
      add("rise_7",      1,  1, 1, 0, 0,  1, 1, 1);
      add("sticky",      1,  1, 0, 0, 0, 40, 1, 1);
      add("clr_c",       1,  1, 0, 0, 1,  1, 1, 0);
      add("clr_c_hold",  1,  1, 0, 0, 1,  3, 1, 0);
      add("svc_h",       1,  1, 0, 1, 0,  5, 1, 0);
      add("fall_h6",     1,  0, 0, 1, 0,  6, 1, 0);
      add("fall_h7",     1,  0, 0, 1, 0,  1, 0, 0);
      add("glitch3",     1,  0, 1, 0, 0,  3, 0, 0);
      add("glitch3_end", 1,  0, 0, 0, 0, 10, 0, 0);
      add("pulse5",      1,  0, 1, 0, 0,  5, 0, 0);
      add("pulse5_end",  1,  0, 0, 0, 0, 10, 0, 1);
      add("sim_pre",     1,  0, 1, 0, 0,  5, 0, 1);
      add("sim_arr",     1,  0, 1, 0, 1,  1, 0, 1);
      add("sim_post",    1,  0, 0, 0, 0,  1, 0, 1);
      add("ind_h",       1,  1, 0, 1, 0, 10, 1, 1);
      add("ind_h_off",   1,  0, 0, 1, 0, 10, 0, 1);
      add("ind_gc",      1,  0, 0, 0, 1,  1, 0, 0);
      add("mid_pre",     1,  1, 0, 0, 0,  8, 1, 0);
      add("mid_rst",     0,  1, 0, 0, 0,  0, 0, 0);
      add("mid_hold",    0,  1, 0, 0, 0,  2, 0, 0);
      add("mid_rel6",    1,  1, 0, 0, 0,  6, 0, 0);
      add("mid_rel7",    1,  1, 0, 0, 0,  1, 1, 0);
      add("end",         1,  0, 0, 1, 0, 10, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
`ifdef VD_COUNT_EN
         if (vecs[i].rst == 1'b0) begin
            run_vec(vecs[i]);
            check({vecs[i].name, ".cnt_h"}, int'(cnt_h), 0);
            check({vecs[i].name, ".cnt_c"}, int'(cnt_c), 0);
         end else begin
            run_vec(vecs[i]);
         end
`else
         run_vec(vecs[i]);
`endif
      end

`ifdef VD_COUNT_EN
      Gh = 1'b0;
      Gc = 1'b0;
      sens_h = 1'b0;
      sens_c = 1'b0;
      reset = 1'b0;
      #1;
      check("sat_rst", int'(cnt_h), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int p = 0; p < 5; p++) begin
         sens_h = 1'b1;
         repeat (6) @(posedge clk);
         @(negedge clk);
         sens_h = 1'b0;
         repeat (10) @(posedge clk);
         @(negedge clk);
         check($sformatf("sat_p%0d", p), int'(cnt_h), (p < 3) ? p + 1 : 3);
      end
      check("sat_cnt_c", int'(cnt_c), 0);
      sens_h = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("sat_mid_rst", int'(cnt_h), 0);
      check("sat_mid_rst.Xh", int'(Xh), 0);
      @(negedge clk);
      reset = 1'b1;
`endif

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vehicle_detect.md
# vehicle_detect

Front-end conditioner for the highway/country traffic-light controller. Takes raw, bouncy loop-detector inputs for the highway and country roads and turns them into the clean, sticky vehicle-request signals `Xh`/`Xc` that the controller consumes. The controller's `Gh`/`Gc` outputs feed back here to acknowledge service and clear the requests. The block sits directly upstream of the controller: two synchronizers, two debouncers, two request latches, and optional traffic counters.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new sensor level must persist before it is accepted; legal range is 2 to 255.
- `CNT_W`, default 8: width of each vehicle counter (present only with `VD_COUNT_EN`).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sens_h` in 1: raw highway loop sensor, asynchronous.
- `sens_c` in 1: raw country loop sensor, asynchronous.
- `Gh` in 1: highway green from the controller; acknowledges highway service.
- `Gc` in 1: country green from the controller; acknowledges country service.
- `Xh` out 1: highway vehicle request to the controller.
- `Xc` out 1: country vehicle request to the controller.
- `cnt_h` out `CNT_W`: highway arrivals, saturating (`VD_COUNT_EN` only).
- `cnt_c` out `CNT_W`: country arrivals, saturating (`VD_COUNT_EN` only).

## Operation
The highway and country channels are identical and fully independent.
- **Synchronizer:** two flops per sensor, producing `s`.
- **Debouncer:**
  - Holds a `stable` level plus a counter `dcnt`.
  - On a cycle where `s == stable`: `dcnt` clears to 0.
  - On a cycle where `s != stable`: `dcnt` increments.
  - When `dcnt == DEBOUNCE_CYCLES-1` and `s != stable`: `stable` takes `s` and `dcnt` clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `stable`.
- **Arrival:** a single-cycle pulse `arr` fires when `stable` goes 0→1.
- **Request latch FSM**, states IDLE and WAIT:
  - IDLE→WAIT when `stable`=1.
  - WAIT→IDLE when green (`Gh`/`Gc`) is sampled 1 and `stable`=0 in the same cycle.
  - In WAIT, `stable` falling while the road is not green does NOT clear the request. The vehicle has passed the loop and is queued at the stop line.
  - In WAIT with green=1 and `stable`=1, the request stays asserted.
  - The output `X` is the registered value (state==WAIT).
- **Simultaneous arrival and clearing condition:** arrival wins. The state stays in or enters WAIT.
- **Cross-road coupling:** none. `Gh` never affects `Xc` and `Gc` never affects `Xh`.

## Timing
- **Reset values:** while `reset`=0, everything is cleared immediately and asynchronously:
  - `Xh`=0, `Xc`=0;
  - sync flops, `stable` and `dcnt` = 0;
  - FSM = IDLE;
  - `cnt_h`, `cnt_c` = 0.
- **Mid-operation reset:** drops `X` at once, with no glitch to 1. After release, the first request needs the full debounce again.
- **Rise latency:** raw sensor rising, held stable, to `X`=1 is `DEBOUNCE_CYCLES`+3 rising edges (2 sync, `DEBOUNCE_CYCLES` debounce, 1 latch).
- **Clear latency:** from the cycle where green=1 and `stable`=0 are both sampled, `X` falls at the next edge.
- **Sensor-fall latency:** a sensor falling during green clears `X` `DEBOUNCE_CYCLES`+3 edges after the raw fall.
- **Green input timing:** `Gh`/`Gc` are synchronous to `clk` (the controller runs on the same clock) and are not resynchronized.
- **Arrival pulse:** `arr` is exactly one cycle wide per accepted 0→1 transition.

## Configuration
- **Macro:** `VD_COUNT_EN`.
- **Defined:**
  - `cnt_h`/`cnt_c` ports and counters exist.
  - Each counter increments by 1 on its `arr` and holds at all-ones (saturates, never wraps).
  - Only reset clears the counters.
- **Undefined:** the ports, the counters and `CNT_W` usage are all removed. `X` behaviour is identical in both builds.

## Structure
- **Shared package `tlc_pkg`:**
  - the request-FSM state enum (IDLE, WAIT);
  - the default `DEBOUNCE_CYCLES` constant;
  - the sync-stage count constant (2).
- **Sub-module `sensor_debounce`:**
  - contains the 2-flop synchronizer, the debouncer and the `arr` pulse;
  - instantiated twice, once per road;
  - the request FSM and the counters stay in `vehicle_detect`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 (7-cycle latency).
- **Reset:** hold `reset`=0 for 3 cycles with `sens_h`=`sens_c`=1 → `Xh`=`Xc`=0 and counts 0 throughout. After release, `Xc` rises on exactly the 7th edge.
- **Glitch rejection:** pulse `sens_c` high for 3 cycles → `Xc` stays 0 and `cnt_c` stays 0. Pulse it for 5 cycles → `Xc`=1 and `cnt_c`=1.
- **Sticky request:**
  - `sens_c` high for 10 cycles then low, with `Gc`=0 for 40 cycles → `Xc` stays 1.
  - Then `Gc`=1 → `Xc`=0 one edge later.
- **Service with vehicles present:**
  - `Gh`=1 while `sens_h` is held high → `Xh` stays 1.
  - Drop `sens_h` → `Xh`=0 exactly 7 edges later.
- **Simultaneity, with `sens_c` pulses 6 cycles wide:**
  - A new country arrival on the same edge as the clearing condition → `Xc` remains 1.
  - Independence check: highway activity leaves `Xc` unaffected.
- **Saturation (`VD_COUNT_EN`, `CNT_W`=2):** 5 clean `sens_h` pulses → `cnt_h` = 1, 2, 3, 3, 3. Reset mid-sequence → `cnt_h`=0 immediately.
